// File: rtl/sprite_mover_if.sv
// Signal bundle between the game logic and the player sprite.
// The master side drives the frame tick, the keys, the crash pulse and the
// scan position. The slave side (the sprite) returns its pixel, its colour,
// its left edge and its crash status.
interface sprite_mover_if;
    logic       refresh_tick;
    logic       left_key;
    logic       right_key;
    logic       pause;
    logic       crash;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       sprite_on;
    logic [11:0] sprite_rgb;
    logic [9:0] sprite_x_l;
    logic       crashed;

    modport master (
        output refresh_tick, left_key, right_key, pause, crash, pixel_x, pixel_y,
        input  sprite_on, sprite_rgb, sprite_x_l, crashed
    );

    modport slave (
        input  refresh_tick, left_key, right_key, pause, crash, pixel_x, pixel_y,
        output sprite_on, sprite_rgb, sprite_x_l, crashed
    );
endinterface

// File: rtl/sprite_mover.sv
// Player sprite for the VGA road game.
// Holds the sprite's left edge, moves it once per frame from the steering
// keys, runs a DRIVE/CRASH state machine (blink, then respawn) and renders a
// scaled 1-bpp bitmap combinationally from the scan position.
// Optional feature: define SPRITE_ACCEL_EN for accelerated motion (signed
// velocity that ramps by one per frame). Without it the sprite moves at a
// constant V_MAX pixels per frame while a single key is held.
module sprite_mover #(
    parameter int          SCREEN_W     = 640,
    parameter int          SPR_W        = 8,
    parameter int          SPR_H        = 16,
    parameter int          SCALE_LOG2   = 2,
    parameter int          Y_TOP        = 410,
    parameter int          X_INIT       = 304,
    parameter int          V_MAX        = 4,
    parameter int          BLINK_FRAMES = 60,
    parameter logic [11:0] COLOR        = 12'h005,
    parameter logic [11:0] CRASH_COLOR  = 12'hF00,
    parameter logic [SPR_W*SPR_H-1:0] BITMAP =
        128'h0000_007E_185A_7E5A_3C7E_FF18_DBFF_DB18
) (
    input  logic           clk,
    input  logic           reset,
    sprite_mover_if.slave  bus
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int W_PIX   = SPR_W << SCALE_LOG2;
    localparam int H_PIX   = SPR_H << SCALE_LOG2;
    localparam int XMAX    = SCREEN_W - W_PIX;
    localparam int BM_BITS = SPR_W * SPR_H;
    localparam int IDX_W   = $clog2(BM_BITS);
    // The blink gate reads bit 3, so the counter is never narrower than 4 bits.
    localparam int CNT_W   = ($clog2(BLINK_FRAMES) < 4) ? 4 : $clog2(BLINK_FRAMES);

    localparam logic        [9:0]       X_INIT_V  = 10'(X_INIT);
    localparam logic        [10:0]      W_PIX_V   = 11'(W_PIX);
    localparam logic        [10:0]      Y_LO_V    = 11'(Y_TOP);
    localparam logic        [10:0]      Y_HI_V    = 11'(Y_TOP + H_PIX);
    localparam logic        [9:0]       Y_TOP_V   = 10'(Y_TOP);
    localparam logic signed [11:0]      XMAX_S    = 12'(XMAX);
    localparam logic        [9:0]       XMAX_V    = 10'(XMAX);
    localparam logic signed [4:0]       VMAX_S    = 5'(V_MAX);
    localparam logic        [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_CRASH = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic        [9:0]      x_l_q, x_l_d;
    logic signed [4:0]      vel_q, vel_d;
    logic        [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                   crash_pend_q, crash_pend_d;

    // Motion candidate for this frame (only committed in DRIVE without crash)
    logic        [9:0]      x_mv;
    logic signed [4:0]      vel_mv;
    logic signed [4:0]      step;
    logic signed [11:0]     sum;
    logic                   right_only;
    logic                   left_only;
    logic                   upd;

    assign right_only = bus.right_key & ~bus.left_key;
    assign left_only  = bus.left_key  & ~bus.right_key;
    assign upd        = bus.refresh_tick & ~bus.pause;

    // State register: every piece of sprite state, async cleared to spawn
    // NOTE: sequential state uses non-blocking (<=) so all registers see the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_DRIVE;
            x_l_q        <= X_INIT_V;
            vel_q        <= '0;
            blink_cnt_q  <= '0;
            crash_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_l_q        <= x_l_d;
            vel_q        <= vel_d;
            blink_cnt_q  <= blink_cnt_d;
            crash_pend_q <= crash_pend_d;
        end
    end

    // Motion: new velocity and step from the keys, then clamped position
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        vel_mv = vel_q;
        step   = '0;
        x_mv   = x_l_q;
        sum    = '0;
`ifdef SPRITE_ACCEL_EN
        if (right_only) begin
            vel_mv = (vel_q >= VMAX_S) ? VMAX_S : vel_q + 5'sd1;
        end else if (left_only) begin
            vel_mv = (vel_q <= -VMAX_S) ? -VMAX_S : vel_q - 5'sd1;
        end else if (vel_q > 5'sd0) begin
            vel_mv = vel_q - 5'sd1;
        end else if (vel_q < 5'sd0) begin
            vel_mv = vel_q + 5'sd1;
        end
        step = vel_mv;
`else
        vel_mv = '0;
        if (right_only) begin
            step = VMAX_S;
        end else if (left_only) begin
            step = -VMAX_S;
        end
`endif
        // Signed sum wide enough that neither edge can wrap.
        sum = $signed({2'b00, x_l_q}) + $signed({{7{step[4]}}, step});
        if (sum <= 12'sd0) begin
            x_mv   = '0;
            vel_mv = '0;
        end else if (sum >= XMAX_S) begin
            x_mv   = XMAX_V;
            vel_mv = '0;
        end else begin
            x_mv   = sum[9:0];
        end
    end

    // Next-state logic for the DRIVE/CRASH machine and the pending crash flag
    always_comb begin
        state_d      = state_q;
        x_l_d        = x_l_q;
        vel_d        = vel_q;
        blink_cnt_d  = blink_cnt_q;
        crash_pend_d = crash_pend_q;

        unique case (state_q)
            ST_DRIVE: begin
                if (upd) begin
                    // A crash wins over motion: the sprite stops where it is.
                    if (bus.crash || crash_pend_q) begin
                        state_d     = ST_CRASH;
                        vel_d       = '0;
                        blink_cnt_d = '0;
                    end else begin
                        x_l_d = x_mv;
                        vel_d = vel_mv;
                    end
                    crash_pend_d = 1'b0;
                end else if (bus.crash) begin
                    // Remember a pulse that arrived between frames.
                    crash_pend_d = 1'b1;
                end
            end
            ST_CRASH: begin
                crash_pend_d = 1'b0;
                if (upd) begin
                    if (blink_cnt_q == CNT_LAST) begin
                        state_d     = ST_DRIVE;
                        x_l_d       = X_INIT_V;
                        vel_d       = '0;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_DRIVE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Render
    // ------------------------------------------------------------------
    logic             in_box;
    logic [9:0]       dx;
    logic [9:0]       dy;
    logic [9:0]       col;
    logic [9:0]       row;
    logic [IDX_W-1:0] bit_idx;
    logic             bm_bit;
    logic             blink_ok;

    // Box test and bitmap lookup from the current scan position
    always_comb begin
        in_box  = ({1'b0, bus.pixel_x} >= {1'b0, x_l_q})
               && ({1'b0, bus.pixel_x} <  ({1'b0, x_l_q} + W_PIX_V))
               && ({1'b0, bus.pixel_y} >= Y_LO_V)
               && ({1'b0, bus.pixel_y} <  Y_HI_V);
        // Full-width offsets; only meaningful (and only used) inside the box.
        dx      = bus.pixel_x - x_l_q;
        dy      = bus.pixel_y - Y_TOP_V;
        col     = dx >> SCALE_LOG2;
        row     = dy >> SCALE_LOG2;
        bit_idx = '0;
        if (in_box) begin
            // Row 0 sits in the MSBs and column 0 is the MSB of its row.
            bit_idx = IDX_W'(BM_BITS - 1 - (int'(row) * SPR_W + int'(col)));
        end
        bm_bit   = BITMAP[bit_idx];
        blink_ok = (state_q != ST_CRASH) || !blink_cnt_q[3];
    end

    assign bus.sprite_on  = in_box & bm_bit & blink_ok;
    assign bus.sprite_rgb = (state_q == ST_CRASH) ? CRASH_COLOR : COLOR;
    assign bus.sprite_x_l = x_l_q;
    assign bus.crashed    = (state_q == ST_CRASH);

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: directed scenarios followed by a
// randomized run, all compared against a frame-level reference model.
module tb_sprite_mover;

    logic clk;
    logic reset;
    sprite_mover_if bus();

    sprite_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [127:0] bm = 128'h0000_007E_185A_7E5A_3C7E_FF18_DBFF_DB18;
    int m_x;
    int m_vel;
    int m_cnt;
    bit m_crashed;
    bit m_pend;

    function automatic void m_reset();
        m_x = 304; m_vel = 0; m_cnt = 0; m_crashed = 0; m_pend = 0;
    endfunction

    // One clock edge with the given inputs.
    function automatic void m_edge(bit tick, bit l, bit r, bit p, bit c);
        bit upd = tick && !p;
        int nx;
        int stp;
        if (m_crashed) begin
            m_pend = 0;
            if (upd) begin
                if (m_cnt == 59) begin
                    m_crashed = 0; m_x = 304; m_vel = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (upd) begin
            if (c || m_pend) begin
                m_crashed = 1; m_vel = 0; m_cnt = 0;
            end else begin
`ifdef SPRITE_ACCEL_EN
                if (r && !l)      m_vel = (m_vel + 1 > 4) ? 4 : m_vel + 1;
                else if (l && !r) m_vel = (m_vel - 1 < -4) ? -4 : m_vel - 1;
                else if (m_vel > 0) m_vel--;
                else if (m_vel < 0) m_vel++;
                stp = m_vel;
`else
                stp = (r && !l) ? 4 : ((l && !r) ? -4 : 0);
`endif
                nx = m_x + stp;
                if (nx <= 0) begin nx = 0; m_vel = 0; end
                else if (nx >= 608) begin nx = 608; m_vel = 0; end
                m_x = nx;
            end
            m_pend = 0;
        end else if (c) begin
            m_pend = 1;
        end
    endfunction

    function automatic bit m_on(int px, int py);
        int row;
        int col;
        if (px < m_x || px >= m_x + 32 || py < 410 || py >= 474) return 0;
        if (m_crashed && ((m_cnt / 8) % 2 == 1)) return 0;
        row = (py - 410) / 4;
        col = (px - m_x) / 4;
        return bm[127 - (row * 8 + col)];
    endfunction

    // ---------------- checking ----------------
    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".x_l"},     int'(bus.sprite_x_l), m_x);
        check({tag, ".crashed"}, int'(bus.crashed),    int'(m_crashed));
        check({tag, ".on"},      int'(bus.sprite_on),
              int'(m_on(int'(bus.pixel_x), int'(bus.pixel_y))));
        check({tag, ".rgb"},     int'(bus.sprite_rgb), m_crashed ? 'hF00 : 'h005);
    endtask

    // One clock with inputs applied on the falling edge, sampled 1 ns after rise.
    task automatic step(string tag, bit tick, bit l, bit r, bit p, bit c);
        @(negedge clk);
        bus.refresh_tick = tick;
        bus.left_key     = l;
        bus.right_key    = r;
        bus.pause        = p;
        bus.crash        = c;
        bus.pixel_x      = 10'(m_x - 4 + $urandom_range(0, 40));
        bus.pixel_y      = 10'(406 + $urandom_range(0, 72));
        @(posedge clk);
        m_edge(tick, l, r, p, c);
        #1;
        check_all(tag);
    endtask

    task automatic render_at(string tag, int px, int py, int exp);
        bus.pixel_x = 10'(px);
        bus.pixel_y = 10'(py);
        #1;
        check(tag, int'(bus.sprite_on), exp);
    endtask

    initial begin
        int guard;
        bus.refresh_tick = 0; bus.left_key = 0; bus.right_key = 0;
        bus.pause = 0; bus.crash = 0; bus.pixel_x = 0; bus.pixel_y = 0;
        reset = 0;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1;

`ifdef SPRITE_ACCEL_EN
        for (int i = 0; i < 6; i++) step("accel_right", 1, 0, 1, 0, 0);
        check("accel_6", int'(bus.sprite_x_l), 322);
        for (int i = 0; i < 4; i++) step("accel_release", 1, 0, 0, 0, 0);
        check("accel_release4", int'(bus.sprite_x_l), 328);
        for (int i = 0; i < 100; i++) step("accel_clamp", 1, 0, 1, 0, 0);
        check("accel_clamp_608", int'(bus.sprite_x_l), 608);
`else
        for (int i = 0; i < 10; i++) step("right", 1, 0, 1, 0, 0);
        check("right_10", int'(bus.sprite_x_l), 344);
        for (int i = 0; i < 100; i++) step("right_clamp", 1, 0, 1, 0, 0);
        check("clamp_608", int'(bus.sprite_x_l), 608);
`endif
        // Both keys: no steering, and ticks without steering leave x put.
        for (int i = 0; i < 6; i++) step("both_keys", 1, 1, 1, 0, 0);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 reset = 0;
        #1;
        m_reset();
        check("async_rst.x_l", int'(bus.sprite_x_l), 304);
        check("async_rst.crashed", int'(bus.crashed), 0);
        @(negedge clk);
        reset = 1;

        // Render at spawn position.
        render_at("render_308_422", 308, 422, 1);
        render_at("render_304_422", 304, 422, 0);
        render_at("render_335_474", 335, 474, 0);
        render_at("render_336_422", 336, 422, 0);
        render_at("render_335_473", 335, 473, int'(m_on(335, 473)));

        // Steer left to about x=200, then clear the keys.
        guard = 0;
        while (m_x > 200 && guard < 200) begin
            step("left", 1, 1, 0, 0, 0);
            guard++;
        end
        check("reach_200", int'(guard < 200), 1);
        for (int i = 0; i < 5; i++) step("coast", 1, 0, 0, 0, 0);

        // Crash pulse between ticks, consumed at the next tick.
        step("crash_pulse", 0, 0, 0, 0, 1);
        check("pend_not_crashed", int'(bus.crashed), 0);
        step("crash_tick", 1, 0, 1, 0, 0);
        check("crashed_after_tick", int'(bus.crashed), 1);
        check("crash_rgb", int'(bus.sprite_rgb), 'hF00);

        // Five blink frames, then pause for 20 ticks with crash and keys wiggling.
        for (int i = 0; i < 5; i++) step("blink", 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("paused", 1, i[0], !i[0], 1, i[1]);
        // 55 frames remain: 54 stay crashed, the 55th respawns.
        for (int i = 0; i < 54; i++) step("blink2", 1, 1, 0, 0, 0);
        check("still_crashed", int'(bus.crashed), 1);
        step("respawn", 1, 0, 0, 0, 0);
        check("respawn.crashed", int'(bus.crashed), 0);
        check("respawn.x_l", int'(bus.sprite_x_l), 304);

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
